blake2b_result_reporter: RTL

//   Consumer side of the blake2b hasher output (hash1/nonce1/valid).
//   - Captures each new result on the rising edge of hash_valid.
//   - Compares the hash against a difficulty target.
//   - Serialises each winning result to the host as a byte frame over a valid/ready stream.
//   - Counts hits, misses and overruns for status readback.

---
 rtl/blake2b_result_reporter_if.sv | 54 +++++
 rtl/blake2b_result_reporter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/blake2b_result_reporter_if.sv
// ---------------------------------------------------------------------------
// blake2b_result_reporter_if
//   Bundles the hasher-result inputs and the outgoing byte stream of the
//   blake2b result reporter.
//
//   Signals
//     hash_in    hash word from the hasher
//     nonce_in   nonce belonging to hash_in
//     hash_valid hasher valid level (edge-detected inside the reporter)
//     target     difficulty target, sampled together with the hash
//     tx_data    frame byte towards the host
//     tx_valid   tx_data is valid
//     tx_ready   host accepts the byte
//
//   Stream handshake: a byte transfers on every rising clk edge where
//   tx_valid && tx_ready. Once tx_valid is high it stays high, and tx_data
//   stays stable, until that transfer happens.
//
//   Modports
//     master  the reporter: consumes hasher results, drives the byte stream
//     slave   the environment: drives hasher results, sinks the byte stream
// ---------------------------------------------------------------------------
interface blake2b_result_reporter_if #(
    parameter int HASH_W  = 128,
    parameter int NONCE_W = 6
);
    logic [HASH_W-1:0]  hash_in;
    logic [NONCE_W-1:0] nonce_in;
    logic               hash_valid;
    logic [HASH_W-1:0]  target;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;

    modport master (
        input  hash_in,
        input  nonce_in,
        input  hash_valid,
        input  target,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );

    modport slave (
        output hash_in,
        output nonce_in,
        output hash_valid,
        output target,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );
endinterface

// File: rtl/blake2b_result_reporter.sv
// ---------------------------------------------------------------------------
// blake2b_result_reporter
//   Captures each new blake2b result on the rising edge of hash_valid,
//   compares the hash against a difficulty target and, on a hit, sends the
//   result to the host as a byte frame:
//     0xA5, {pad, nonce}, hash bytes MSB first, XOR checksum of bytes 1..N-2
//   Hits (frames fully sent), misses and lost results (overrun) are counted.
//
//   Ports
//     clk       system clock, everything on posedge
//     rst_n     asynchronous active-low reset
//     bus       master side of blake2b_result_reporter_if (results in,
//               byte stream out)
//     clr       synchronous clear of hit_cnt, miss_cnt and overrun
//     busy      high while comparing or sending
//     found     sticky, at least one hit since reset
//     overrun   sticky, a result edge arrived while busy and was dropped
//     hit_cnt   saturating count of frames fully sent
//     miss_cnt  saturating count of results with hash >= target
//     state_o   current FSM state (0 IDLE, 1 CMP, 2 SEND) for observation
// ---------------------------------------------------------------------------
module blake2b_result_reporter #(
    parameter int HASH_W  = 128,
    parameter int NONCE_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    blake2b_result_reporter_if.master bus,
    input  logic                      clr,
    output logic                      busy,
    output logic                      found,
    output logic                      overrun,
    output logic [CNT_W-1:0]          hit_cnt,
    output logic [CNT_W-1:0]          miss_cnt,
    output logic [1:0]                state_o
);
    localparam int HB    = HASH_W / 8;
    localparam int N     = 3 + HB;
    localparam int IDX_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               hash_valid_q;
    logic [HASH_W-1:0]  hash_q, hash_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [HASH_W-1:0]  target_q, target_d;
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic               found_q, found_d;
    logic               overrun_q, overrun_d;
    logic [CNT_W-1:0]   hit_q, hit_d;
    logic [CNT_W-1:0]   miss_q, miss_d;

    logic               rise;
    logic [7:0]         nonce_byte;
    logic [7:0]         checksum;
    logic [7:0]         hash_byte;
    logic [7:0]         frame_byte;
    int                 hb_idx;

    // hash_valid_q resets to 0, so a level already high at reset release
    // counts as a fresh result.
    assign rise = bus.hash_valid & ~hash_valid_q;

    // ------------------------------------------------------------------
    // Frame byte selection from the captured result
    // ------------------------------------------------------------------
    always_comb begin
        nonce_byte                = '0;
        nonce_byte[NONCE_W-1:0]   = nonce_q;

        checksum = nonce_byte;
        for (int i = 0; i < HB; i++) begin
            checksum = checksum ^ hash_q[HASH_W-1-8*i -: 8];
        end

        // Hash byte j (0 = most significant) sits at bit offset HASH_W-8-8*j.
        hb_idx = int'(byte_idx_q) - 2;
        if (hb_idx < 0 || hb_idx > HB - 1) begin
            hb_idx = 0;
        end
        hash_byte = 8'(hash_q >> (HASH_W - 8 - 8 * hb_idx));

        if (byte_idx_q == IDX_W'(0)) begin
            frame_byte = 8'hA5;
        end else if (byte_idx_q == IDX_W'(1)) begin
            frame_byte = nonce_byte;
        end else if (byte_idx_q == IDX_W'(N - 1)) begin
            frame_byte = checksum;
        end else begin
            frame_byte = hash_byte;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        hash_d     = hash_q;
        nonce_d    = nonce_q;
        target_d   = target_q;
        byte_idx_d = byte_idx_q;
        found_d    = found_q;
        overrun_d  = overrun_q;
        hit_d      = hit_q;
        miss_d     = miss_q;

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    hash_d   = bus.hash_in;
                    nonce_d  = bus.nonce_in;
                    target_d = bus.target;
                    state_d  = CMP;
                end
            end

            CMP: begin
                // A result arriving now is dropped; the captured one proceeds.
                if (rise) begin
                    overrun_d = 1'b1;
                end
                if (hash_q < target_q) begin
                    found_d    = 1'b1;
                    byte_idx_d = '0;
                    state_d    = SEND;
                end else begin
                    if (miss_q != '1) begin
                        miss_d = miss_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end
            end

            SEND: begin
                if (rise) begin
                    overrun_d = 1'b1;
                end
                // tx_valid is high throughout SEND, so tx_ready alone
                // completes the handshake.
                if (bus.tx_ready) begin
                    if (byte_idx_q == IDX_W'(N - 1)) begin
                        if (hit_q != '1) begin
                            hit_d = hit_q + CNT_W'(1);
                        end
                        byte_idx_d = '0;
                        state_d    = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear overrides any increment or overrun set in the same cycle.
        if (clr) begin
            hit_d     = '0;
            miss_d    = '0;
            overrun_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hash_valid_q <= 1'b0;
            hash_q       <= '0;
            nonce_q      <= '0;
            target_q     <= '0;
            byte_idx_q   <= '0;
            found_q      <= 1'b0;
            overrun_q    <= 1'b0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            hash_valid_q <= bus.hash_valid;
            hash_q       <= hash_d;
            nonce_q      <= nonce_d;
            target_q     <= target_d;
            byte_idx_q   <= byte_idx_d;
            found_q      <= found_d;
            overrun_q    <= overrun_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. tx_valid follows the state register, so reset drops it
    // immediately and a partial frame is abandoned.
    // ------------------------------------------------------------------
    assign bus.tx_valid = (state_q == SEND);
    assign bus.tx_data  = (state_q == SEND) ? frame_byte : 8'h00;
    assign busy         = (state_q != IDLE);
    assign found        = found_q;
    assign overrun      = overrun_q;
    assign hit_cnt      = hit_q;
    assign miss_cnt     = miss_q;
    assign state_o      = state_q;

endmodule
